// File: rtl/ccip_mmio_rsp_engine.sv
// CCI-P MMIO responder: registers host writes to CSR space, queues host reads and issues them
// one at a time to user CSR logic. Optional read timeout build macro: MMIO_RD_TIMEOUT_EN.
module ccip_mmio_rsp_engine #(
  parameter int RD_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        pClk,
  input  logic        pReset_n,
  input  logic [27:0] c0_rx_hdr,
  input  logic [63:0] c0_rx_data,
  input  logic        c0_rx_mmioRdValid,
  input  logic        c0_rx_mmioWrValid,
  output logic [8:0]  c2_tx_hdr,
  output logic        c2_tx_mmioRdValid,
  output logic [63:0] c2_tx_data,
  output logic        csr_wr_valid,
  output logic [15:0] csr_wr_addr,
  output logic        csr_wr_len8,
  output logic [63:0] csr_wr_data,
  output logic        csr_rd_req,
  output logic [15:0] csr_rd_addr,
  output logic        csr_rd_len8,
  output logic [8:0]  csr_rd_tid,
  input  logic        csr_rd_rsp_valid,
  input  logic [8:0]  csr_rd_rsp_tid,
  input  logic [63:0] csr_rd_rsp_data,
  output logic        err_rd_overflow,
  output logic        err_len,
  output logic        err_rd_timeout
);

  localparam int          AW       = $clog2(RD_FIFO_DEPTH);
  localparam int          EW       = 27;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  logic unused_rsvd;
  assign unused_rsvd = c0_rx_hdr[9];

  // Write path: fully independent of reads, one register stage.
  logic        wr_ok;
  logic        wr_vld_q;
  logic [15:0] wr_addr_q;
  logic        wr_len8_q;
  logic [63:0] wr_data_q;

  assign wr_ok = c0_rx_mmioWrValid && !c0_rx_hdr[11];

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_len8_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_vld_q <= wr_ok;
      if (wr_ok) begin
        wr_addr_q <= c0_rx_hdr[27:12];
        wr_len8_q <= c0_rx_hdr[10];
        wr_data_q <= c0_rx_data;
      end
    end
  end

  // Read FIFO entries are {tid, addr, length}.
  logic [EW-1:0] fifo_mem [RD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_empty, fifo_full, push, pop;
  logic [EW-1:0] head;

  state_t        state_q, state_d;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push       = c0_rx_mmioRdValid && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q];

  always_ff @(posedge pClk) begin
    if (push) fifo_mem[wr_ptr_q] <= {c0_rx_hdr[8:0], c0_rx_hdr[27:12], c0_rx_hdr[11:10]};
  end

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Read issue FSM: one read outstanding, responses leave in pop order.
  logic [8:0]  tid_q, tid_d;
  logic [15:0] addr_q, addr_d;
  logic        len8_q, len8_d;
  logic        rd_req_q, rd_req_d;
  logic        c2_vld_q, c2_vld_d;
  logic [8:0]  c2_hdr_q, c2_hdr_d;
  logic [63:0] c2_data_q, c2_data_d;
  logic        err_len_q, err_len_d;
  logic        err_ovf_q, err_ovf_d;
  logic        rd_len_err;
  logic        rsp_match;

  assign rsp_match = csr_rd_rsp_valid && (csr_rd_rsp_tid == tid_q);

`ifdef MMIO_RD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_tmo_q, err_tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    tid_d      = tid_q;
    addr_d     = addr_q;
    len8_d     = len8_q;
    rd_req_d   = 1'b0;
    c2_vld_d   = 1'b0;
    c2_hdr_d   = c2_hdr_q;
    c2_data_d  = c2_data_q;
    rd_len_err = 1'b0;
`ifdef MMIO_RD_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_tmo_d  = err_tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          tid_d  = head[26:18];
          addr_d = head[17:2];
          len8_d = head[0];
          if (head[1]) begin
            rd_len_err = 1'b1;
            state_d    = S_RESP;
            c2_vld_d   = 1'b1;
            c2_hdr_d   = head[26:18];
            c2_data_d  = '0;
          end else begin
            state_d  = S_REQ;
            rd_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef MMIO_RD_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (rsp_match) begin
          state_d   = S_RESP;
          c2_vld_d  = 1'b1;
          c2_hdr_d  = tid_q;
          c2_data_d = csr_rd_rsp_data;
        end
`ifdef MMIO_RD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_RESP;
          c2_vld_d  = 1'b1;
          c2_hdr_d  = tid_q;
          c2_data_d = '1;
          err_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    err_len_d = err_len_q | rd_len_err | (c0_rx_mmioWrValid & c0_rx_hdr[11]);
    err_ovf_d = err_ovf_q | (c0_rx_mmioRdValid & fifo_full & ~pop);
  end

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= S_IDLE;
      tid_q     <= '0;
      addr_q    <= '0;
      len8_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      c2_vld_q  <= 1'b0;
      c2_hdr_q  <= '0;
      c2_data_q <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      addr_q    <= addr_d;
      len8_q    <= len8_d;
      rd_req_q  <= rd_req_d;
      c2_vld_q  <= c2_vld_d;
      c2_hdr_q  <= c2_hdr_d;
      c2_data_q <= c2_data_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef MMIO_RD_TIMEOUT_EN
  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_rd_timeout = err_tmo_q;
`else
  assign err_rd_timeout = 1'b0;
`endif

  assign c2_tx_hdr         = c2_hdr_q;
  assign c2_tx_mmioRdValid = c2_vld_q;
  assign c2_tx_data        = c2_data_q;
  assign csr_wr_valid      = wr_vld_q;
  assign csr_wr_addr       = wr_addr_q;
  assign csr_wr_len8       = wr_len8_q;
  assign csr_wr_data       = wr_data_q;
  assign csr_rd_req        = rd_req_q;
  assign csr_rd_addr       = addr_q;
  assign csr_rd_len8       = len8_q;
  assign csr_rd_tid        = tid_q;
  assign err_rd_overflow   = err_ovf_q;
  assign err_len           = err_len_q;

endmodule

// File: tb/tb_ccip_mmio_rsp_engine.sv
// Bench for ccip_mmio_rsp_engine: scenario tasks plus a c2 response scoreboard and a user CSR model.
module tb_ccip_mmio_rsp_engine;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        pClk = 1'b0;
  logic        pReset_n = 1'b0;
  logic [27:0] c0_rx_hdr = '0;
  logic [63:0] c0_rx_data = '0;
  logic        c0_rx_mmioRdValid = 1'b0;
  logic        c0_rx_mmioWrValid = 1'b0;
  logic [8:0]  c2_tx_hdr;
  logic        c2_tx_mmioRdValid;
  logic [63:0] c2_tx_data;
  logic        csr_wr_valid;
  logic [15:0] csr_wr_addr;
  logic        csr_wr_len8;
  logic [63:0] csr_wr_data;
  logic        csr_rd_req;
  logic [15:0] csr_rd_addr;
  logic        csr_rd_len8;
  logic [8:0]  csr_rd_tid;
  logic        csr_rd_rsp_valid = 1'b0;
  logic [8:0]  csr_rd_rsp_tid = '0;
  logic [63:0] csr_rd_rsp_data = '0;
  logic        err_rd_overflow, err_len, err_rd_timeout;

  always #5 pClk = ~pClk;

  ccip_mmio_rsp_engine #(.RD_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pClk(pClk), .pReset_n(pReset_n), .c0_rx_hdr(c0_rx_hdr), .c0_rx_data(c0_rx_data),
    .c0_rx_mmioRdValid(c0_rx_mmioRdValid), .c0_rx_mmioWrValid(c0_rx_mmioWrValid),
    .c2_tx_hdr(c2_tx_hdr), .c2_tx_mmioRdValid(c2_tx_mmioRdValid), .c2_tx_data(c2_tx_data),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_len8(csr_wr_len8),
    .csr_wr_data(csr_wr_data), .csr_rd_req(csr_rd_req), .csr_rd_addr(csr_rd_addr),
    .csr_rd_len8(csr_rd_len8), .csr_rd_tid(csr_rd_tid), .csr_rd_rsp_valid(csr_rd_rsp_valid),
    .csr_rd_rsp_tid(csr_rd_rsp_tid), .csr_rd_rsp_data(csr_rd_rsp_data),
    .err_rd_overflow(err_rd_overflow), .err_len(err_len), .err_rd_timeout(err_rd_timeout)
  );

  logic [185:0] all_out;
  assign all_out = {c2_tx_hdr, c2_tx_mmioRdValid, c2_tx_data, csr_wr_valid, csr_wr_addr,
                    csr_wr_len8, csr_wr_data, csr_rd_req, csr_rd_addr, csr_rd_len8, csr_rd_tid,
                    err_rd_overflow, err_len, err_rd_timeout};

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;

  bit          rsp_stall = 1'b0;
  bit          inj_req = 1'b0;
  logic [8:0]  inj_tid = '0;
  logic [63:0] inj_data = '0;
  bit          pend = 1'b0;
  logic [8:0]  p_tid = '0;
  logic [15:0] p_addr = '0;

  function automatic logic [63:0] user_data(input logic [15:0] a);
    return (a == 16'h0004) ? 64'h0000_0000_CAFE_F00D : {16'hBEEF, a, 16'h1234, ~a};
  endfunction

  always @(posedge pClk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  // User CSR model: answers each csr_rd_req one cycle later unless stalled.
  initial forever begin
    tick();
    if (!pReset_n) begin
      pend = 1'b0;
      csr_rd_rsp_valid = 1'b0;
    end else if (inj_req) begin
      csr_rd_rsp_valid = 1'b1;
      csr_rd_rsp_tid   = inj_tid;
      csr_rd_rsp_data  = inj_data;
      inj_req = 1'b0;
    end else if (pend && !rsp_stall) begin
      csr_rd_rsp_valid = 1'b1;
      csr_rd_rsp_tid   = p_tid;
      csr_rd_rsp_data  = user_data(p_addr);
      pend = 1'b0;
    end else begin
      csr_rd_rsp_valid = 1'b0;
    end
    if (pReset_n && csr_rd_req === 1'b1) begin
      pend   = 1'b1;
      p_tid  = csr_rd_tid;
      p_addr = csr_rd_addr;
    end
  end

  // c2 scoreboard
  initial forever begin
    exp_t e;
    tick();
    if (c2_tx_mmioRdValid === 1'b1) begin
      rsp_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL c2_unexpected: got tid=%h data=%h at cycle %0d, required no response",
                 c2_tx_hdr, c2_tx_data, cyc);
      end else begin
        e = sb.pop_front();
        if (c2_tx_hdr !== e.tid || c2_tx_data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL c2_rsp: got tid=%h data=%h cycle=%0d, required tid=%h data=%h cycle=%0d",
                   c2_tx_hdr, c2_tx_data, cyc, e.tid, e.data, e.cyc);
        end
      end
    end
  end

  task automatic drain(input int budget, output bit ok);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    tick();
    ok = (sb.size() == 0);
  endtask

  task automatic send_rd(input logic [8:0] tid, input logic [15:0] addr, input logic [1:0] len);
    c0_rx_hdr = {addr, len, 1'b0, tid};
    c0_rx_mmioRdValid = 1'b1;
    tick();
    c0_rx_mmioRdValid = 1'b0;
  endtask

  task automatic test_reset();
    pReset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_out); end
    pReset_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (all_out !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h, required 0", all_out); end
  endtask

  task automatic test_write();
    c0_rx_hdr = {16'h0010, 2'b01, 1'b0, 9'h000};
    c0_rx_data = 64'h1122334455667788;
    c0_rx_mmioWrValid = 1'b1;
    tick();
    c0_rx_mmioWrValid = 1'b0;
    n_cmp++;
    if ({csr_wr_valid, csr_wr_addr, csr_wr_len8, csr_wr_data} !== {1'b1, 16'h0010, 1'b1, 64'h1122334455667788}) begin
      n_fail++;
      $display("FAIL wr8: got v=%b a=%h l8=%b d=%h, required v=1 a=0010 l8=1 d=1122334455667788",
               csr_wr_valid, csr_wr_addr, csr_wr_len8, csr_wr_data);
    end
    tick();
    n_cmp++;
    if (csr_wr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b, required 0", csr_wr_valid); end
    c0_rx_hdr = {16'h0123, 2'b00, 1'b0, 9'h000};
    c0_rx_data = 64'hAAAABBBBDEADBEEF;
    c0_rx_mmioWrValid = 1'b1;
    tick();
    c0_rx_mmioWrValid = 1'b0;
    n_cmp++;
    if ({csr_wr_valid, csr_wr_addr, csr_wr_len8, csr_wr_data} !== {1'b1, 16'h0123, 1'b0, 64'hAAAABBBBDEADBEEF}) begin
      n_fail++;
      $display("FAIL wr4: got v=%b a=%h l8=%b d=%h, required v=1 a=0123 l8=0 d=aaaabbbbdeadbeef",
               csr_wr_valid, csr_wr_addr, csr_wr_len8, csr_wr_data);
    end
    tick();
  endtask

  task automatic test_read();
    c0_rx_hdr = {16'h0004, 2'b00, 1'b0, 9'h005};
    c0_rx_data = 64'h0000000012345678;
    c0_rx_mmioRdValid = 1'b1;
    c0_rx_mmioWrValid = 1'b1;
    sb.push_back('{tid: 9'h005, data: 64'h00000000CAFEF00D, cyc: cyc + 4});
    tick();
    c0_rx_mmioRdValid = 1'b0;
    c0_rx_mmioWrValid = 1'b0;
    n_cmp++;
    if ({csr_wr_valid, csr_wr_addr, csr_wr_data} !== {1'b1, 16'h0004, 64'h0000000012345678}) begin
      n_fail++;
      $display("FAIL wr_with_rd: got v=%b a=%h d=%h, required v=1 a=0004 d=12345678",
               csr_wr_valid, csr_wr_addr, csr_wr_data);
    end
    tick();
    n_cmp++;
    if ({csr_rd_req, csr_rd_addr, csr_rd_len8, csr_rd_tid} !== {1'b1, 16'h0004, 1'b0, 9'h005}) begin
      n_fail++;
      $display("FAIL rd_req: got r=%b a=%h l8=%b t=%h, required r=1 a=0004 l8=0 t=005",
               csr_rd_req, csr_rd_addr, csr_rd_len8, csr_rd_tid);
    end
    begin
      bit ok;
      drain(20, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rd_drain: got %0d pending, required 0", sb.size()); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rsp_stall = 1'b1;
    n_cmp++;
    if (err_rd_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b, required 0", err_rd_overflow); end
    send_rd(9'h010, 16'h0100, 2'b01);
    sb.push_back('{tid: 9'h010, data: user_data(16'h0100), cyc: -1});
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) sb.push_back('{tid: 9'(i), data: user_data(16'h0200 + 16'(i)), cyc: -1});
      send_rd(9'(i), 16'h0200 + 16'(i), 2'b01);
    end
    tick();
    n_cmp++;
    if (err_rd_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", err_rd_overflow); end
    rsp_stall = 1'b0;
    drain(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
    repeat (10) tick();
  endtask

  task automatic test_len_err();
    bit ok;
    int reqs;
    n_cmp++;
    if (err_len !== 1'b0) begin n_fail++; $display("FAIL len_pre: got %b, required 0", err_len); end
    sb.push_back('{tid: 9'h1FF, data: 64'h0, cyc: cyc + 2});
    send_rd(9'h1FF, 16'h0040, 2'b10);
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      if (csr_rd_req === 1'b1) reqs++;
      tick();
    end
    n_cmp++;
    if (reqs != 0) begin n_fail++; $display("FAIL len_no_req: got %0d requests, required 0", reqs); end
    n_cmp++;
    if (err_len !== 1'b1) begin n_fail++; $display("FAIL len_rd_err: got %b, required 1", err_len); end
    drain(10, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL len_drain: got %0d pending, required 0", sb.size()); end
    pReset_n = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    n_cmp++;
    if (err_len !== 1'b0) begin n_fail++; $display("FAIL len_clear: got %b, required 0", err_len); end
    c0_rx_hdr = {16'h0077, 2'b11, 1'b0, 9'h000};
    c0_rx_data = 64'h5555;
    c0_rx_mmioWrValid = 1'b1;
    tick();
    c0_rx_mmioWrValid = 1'b0;
    n_cmp++;
    if ({csr_wr_valid, err_len} !== 2'b01) begin
      n_fail++;
      $display("FAIL len_wr: got wr_valid=%b err_len=%b, required 0 1", csr_wr_valid, err_len);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    rsp_stall = 1'b1;
    n_cmp++;
    if (err_rd_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pre: got %b, required 0", err_rd_timeout); end
`ifdef MMIO_RD_TIMEOUT_EN
    begin
      bit seen;
      sb.push_back('{tid: 9'h00A, data: 64'hFFFF_FFFF_FFFF_FFFF, cyc: -1});
      send_rd(9'h00A, 16'h0008, 2'b01);
      drain(TMO + 20, ok);
      n_cmp++;
      if (!ok || err_rd_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL tmo_fire: got pending=%0d err=%b, required 0 1", sb.size(), err_rd_timeout);
      end
      sb.push_back('{tid: 9'h00B, data: user_data(16'h000C), cyc: -1});
      send_rd(9'h00B, 16'h000C, 2'b01);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (csr_rd_req === 1'b1) seen = 1'b1;
        else tick();
      end
      n_cmp++;
      if (!seen) begin n_fail++; $display("FAIL tmo_next_req: got no csr_rd_req, required one"); end
      tick();
      inj_tid = 9'h00A;
      inj_data = 64'hBAD0_BAD0_BAD0_BAD0;
      inj_req = 1'b1;
      repeat (3) tick();
      rsp_stall = 1'b0;
      drain(TMO + 20, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL tmo_stale: got %0d pending, required 0", sb.size()); end
    end
`else
    begin
      int c0;
      sb.push_back('{tid: 9'h00A, data: user_data(16'h0008), cyc: -1});
      c0 = rsp_cnt;
      send_rd(9'h00A, 16'h0008, 2'b01);
      repeat (3 * TMO) tick();
      n_cmp++;
      if (rsp_cnt != c0 || err_rd_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL no_tmo: got rsps=%0d err=%b, required 0 0", rsp_cnt - c0, err_rd_timeout);
      end
      rsp_stall = 1'b0;
      drain(20, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL no_tmo_drain: got %0d pending, required 0", sb.size()); end
    end
`endif
    rsp_stall = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c0;
    rsp_stall = 1'b1;
    send_rd(9'h021, 16'h0300, 2'b01);
    send_rd(9'h022, 16'h0301, 2'b01);
    send_rd(9'h023, 16'h0302, 2'b01);
    repeat (2) tick();
    pReset_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin n_fail++; $display("FAIL mid_reset: got %h, required 0", all_out); end
    repeat (3) tick();
    pReset_n = 1'b1;
    rsp_stall = 1'b0;
    c0 = rsp_cnt;
    repeat (20) tick();
    n_cmp++;
    if (rsp_cnt != c0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d rsps, required 0", rsp_cnt - c0); end
    sb.push_back('{tid: 9'h030, data: user_data(16'h0050), cyc: cyc + 4});
    send_rd(9'h030, 16'h0050, 2'b01);
    drain(20, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL post_reset_rd: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_len_err();
    test_timeout();
    test_reset_mid();
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
